// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encoding and baud divisor helper for the uart
package uart_pkg;

    // Ticks per bit period
    localparam int OVERSAMPLE = 16;

    // Shared by the RX and TX framing FSMs
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Clocks per oversample tick, truncated
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: bundle between the debug controller / serial pins and the uart
//   master (debugger + line side): drives rx, tx_data, wr_en, rd_en
//   slave  (uart): drives tx, tx_full, rx_data, rx_empty, rx_frame_err, rx_ovf
interface uart_if;
    logic       rx;
    logic       tx;
    logic [7:0] tx_data;
    logic       wr_en;
    logic       rd_en;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_frame_err;
    logic       rx_ovf;

    modport master (
        output rx, tx_data, wr_en, rd_en,
        input  tx, tx_full, rx_data, rx_empty, rx_frame_err, rx_ovf
    );

    modport slave (
        input  rx, tx_data, wr_en, rd_en,
        output tx, tx_full, rx_data, rx_empty, rx_frame_err, rx_ovf
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit first-word fall-through FIFO, depth 2**FIFO_ADDR_BITS
//   clk, rst_n   : clock, async active-low reset
//   din, wr_en   : push (ignored when full)
//   rd_en        : pop (ignored when empty)
//   dout         : registered head of queue
//   full, empty  : decoded from the extra pointer MSB
module uart_fifo #(
    parameter int FIFO_ADDR_BITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = FIFO_ADDR_BITS;
    localparam int PW = FIFO_ADDR_BITS + 1;

    logic [7:0]    mem [1 << AW];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic          do_wr, do_rd;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_next = rd_ptr + PW'(do_rd);

    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;

    // The head register bypasses din when the write lands in the slot that becomes the head
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_wr);
            rd_ptr <= rd_next;
            if (do_wr && rd_next[AW-1:0] == wr_ptr[AW-1:0]) dout <= din;
            else if (rd_next != wr_ptr) dout <= mem[rd_next[AW-1:0]];
        end
endmodule

// File: rtl/uart.sv
// uart: 8N1 serial front end with 16x oversampling and 8-deep FIFOs per direction
//   clk, rst_n : system clock, async active-low reset
//   bus.slave  : rx/tx serial pins, TX push (tx_data, wr_en, tx_full),
//                RX pop (rd_en, rx_data, rx_empty), rx_frame_err / rx_ovf pulses
module uart
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE      = 38400,
    parameter int FIFO_ADDR_BITS = 3
) (
    input logic   clk,
    input logic   rst_n,
    uart_if.slave bus
);
    localparam int         BAUD_DIV = baud_div(SYS_CLK_FREQ, BAUD_RATE);
    localparam int         CW       = $clog2(BAUD_DIV + 1);
    localparam logic [3:0] LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID      = 4'(OVERSAMPLE / 2 - 1);

    logic [CW-1:0] baud_cnt;
    logic          tick;
    logic [1:0]    rx_meta;
    logic          rx_s;

    assign tick = baud_cnt == CW'(BAUD_DIV - 1);
    assign rx_s = rx_meta[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            baud_cnt <= '0;
            rx_meta  <= 2'b11;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            rx_meta  <= {rx_meta[0], bus.rx};
        end

    state_t     rx_state, rx_state_n;
    logic [3:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shreg, rx_shreg_n;
    logic       rx_armed, rx_armed_n, rx_push, rx_full, ferr_n, ovf_n;

    // rx_armed requires the line to be seen high in IDLE before a start edge is accepted,
    // so a line stuck low (after reset or a framing error) cannot start new frames
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        rx_armed_n = rx_armed;
        rx_push    = 1'b0;
        ferr_n     = 1'b0;
        ovf_n      = 1'b0;
        if (tick) begin
            rx_cnt_n = rx_cnt + 1'b1;
            case (rx_state)
                IDLE: begin
                    rx_cnt_n = '0;
                    if (rx_s) rx_armed_n = 1'b1;
                    else if (rx_armed) begin
                        rx_state_n = START;
                        rx_armed_n = 1'b0;
                    end
                end
                START: if (rx_cnt == MID) begin
                    rx_state_n = rx_s ? IDLE : DATA;
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                end
                DATA: if (rx_cnt == LAST) begin
                    rx_shreg_n = {rx_s, rx_shreg[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = STOP;
                end
                STOP: if (rx_cnt == LAST) begin
                    rx_state_n = IDLE;
                    rx_push    = rx_s && !rx_full;
                    ovf_n      = rx_s && rx_full;
                    ferr_n     = !rx_s;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_state         <= IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_shreg         <= '0;
            rx_armed         <= 1'b0;
            bus.rx_frame_err <= 1'b0;
            bus.rx_ovf       <= 1'b0;
        end else begin
            rx_state         <= rx_state_n;
            rx_cnt           <= rx_cnt_n;
            rx_bit           <= rx_bit_n;
            rx_shreg         <= rx_shreg_n;
            rx_armed         <= rx_armed_n;
            bus.rx_frame_err <= ferr_n;
            bus.rx_ovf       <= ovf_n;
        end

    uart_fifo #(.FIFO_ADDR_BITS(FIFO_ADDR_BITS)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .din(rx_shreg), .wr_en(rx_push), .rd_en(bus.rd_en),
        .dout(bus.rx_data), .full(rx_full), .empty(bus.rx_empty)
    );

    state_t     tx_state, tx_state_n;
    logic [3:0] tx_cnt, tx_cnt_n;
    logic [2:0] tx_bit, tx_bit_n;
    logic [7:0] tx_shreg, tx_shreg_n, tx_head;
    logic       tx_pop, tx_empty, tx_d;

    // A byte waiting at the end of a stop bit is loaded on that same tick, so frames abut
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_cnt_n = tx_cnt + 1'b1;
            case (tx_state)
                IDLE: begin
                    tx_cnt_n = '0;
                    tx_pop   = !tx_empty;
                end
                START: if (tx_cnt == LAST) begin
                    tx_state_n = DATA;
                    tx_bit_n   = '0;
                end
                DATA: if (tx_cnt == LAST) begin
                    tx_shreg_n = tx_shreg >> 1;
                    tx_bit_n   = tx_bit + 1'b1;
                    if (tx_bit == 3'd7) tx_state_n = STOP;
                end
                STOP: if (tx_cnt == LAST) begin
                    tx_state_n = IDLE;
                    tx_pop     = !tx_empty;
                end
                default: ;
            endcase
            if (tx_pop) begin
                tx_state_n = START;
                tx_shreg_n = tx_head;
            end
        end
    end

    assign tx_d = (tx_state_n == START) ? 1'b0 : (tx_state_n == DATA) ? tx_shreg_n[0] : 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            bus.tx   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shreg <= tx_shreg_n;
            bus.tx   <= tx_d;
        end

    uart_fifo #(.FIFO_ADDR_BITS(FIFO_ADDR_BITS)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .din(bus.tx_data), .wr_en(bus.wr_en), .rd_en(tx_pop),
        .dout(tx_head), .full(bus.tx_full), .empty(tx_empty)
    );
endmodule

// File: tb/tb_uart.sv
// tb_uart: self-checking bench for uart (scaled-down baud so frames stay short)
module tb_uart;
    localparam int SYS  = 1_000_000;
    localparam int BAUD = 12_000;
    localparam int DIV  = SYS / (BAUD * 16);
    localparam int BIT  = 16 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_if bus();

    uart #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .FIFO_ADDR_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0, failures = 0, cyc = 0, ferr_cnt = 0, ovf_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (bus.rx_frame_err) ferr_cnt++;
        if (bus.rx_ovf) ovf_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        bus.rx = 1'b1;
    endtask

    task automatic pop_rx();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    // Walks one TX frame cycle by cycle; j0 > 0 means the start bit began j0 cycles ago.
    // Cycles adjacent to bit boundaries are skipped to allow +/-1 clock of edge placement.
    task automatic tx_frame(input logic [7:0] d, input int j0, output int fall);
        logic [9:0] f;
        int bad, t;
        f = {1'b1, d, 1'b0};
        bad = 0;
        t = 0;
        while (j0 == 0 && bus.tx !== 1'b0 && t < 40 * BIT) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("tx start bit of %02h", d), bus.tx, 1'b0);
        fall = cyc - j0;
        for (int j = j0; j < 10 * BIT; j++) begin
            if (j % BIT != 0 && j % BIT != BIT - 1 && bus.tx !== f[j / BIT]) bad++;
            @(negedge clk);
        end
        check($sformatf("tx frame %02h bad cycles", d), bad, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_byte;
        int         exp_ferr;
    } rx_vec_t;

    rx_vec_t    vecs[6];
    logic [7:0] q[$];
    logic [7:0] tq[$];
    logic [7:0] b;
    int f0, o0, exp_ovf, wc, fall, prev, lows, t;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h7F, 1'b0, 1'b0, 1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1};

        bus.rx = 1'b1;
        bus.tx_data = 8'h00;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset tx", bus.tx, 1'b1);
        check("reset tx_full", bus.tx_full, 1'b0);
        check("reset rx_empty", bus.rx_empty, 1'b1);
        check("reset rx_data", bus.rx_data, 8'h00);
        check("reset rx_frame_err", bus.rx_frame_err, 1'b0);
        check("reset rx_ovf", bus.rx_ovf, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Table of single RX frames, each fully checked and drained
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            repeat ($urandom_range(0, 2 * DIV)) @(negedge clk);
            send_rx(vecs[i].data, vecs[i].stop);
            repeat (BIT) @(negedge clk);
            check($sformatf("vec%0d frame_err pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d rx_empty", i), bus.rx_empty, !vecs[i].exp_byte);
            if (vecs[i].exp_byte) begin
                check($sformatf("vec%0d rx_data", i), bus.rx_data, vecs[i].data);
                pop_rx();
                check($sformatf("vec%0d empty after pop", i), bus.rx_empty, 1'b1);
            end
        end

        // Back-to-back 0x55, 0xA3: both queued, read in order, no error pulses
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        send_rx(8'h55, 1'b1);
        send_rx(8'hA3, 1'b1);
        repeat (BIT) @(negedge clk);
        check("pair head", bus.rx_data, 8'h55);
        pop_rx();
        check("pair second", bus.rx_data, 8'hA3);
        check("pair not empty", bus.rx_empty, 1'b0);
        pop_rx();
        check("pair empty", bus.rx_empty, 1'b1);
        check("pair no errors", (ferr_cnt - f0) + (ovf_cnt - o0), 0);

        // Nine random frames with no reads: eight kept in order, one overflow pulse
        o0 = ovf_cnt;
        exp_ovf = 0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (q.size() < 8) q.push_back(b);
            else exp_ovf++;
        end
        repeat (BIT) @(negedge clk);
        check("overflow pulses", ovf_cnt - o0, exp_ovf);
        while (q.size() > 0) begin
            b = q.pop_front();
            check("overflow rx_empty", bus.rx_empty, 1'b0);
            check("overflow order", bus.rx_data, b);
            pop_rx();
        end
        check("overflow drained", bus.rx_empty, 1'b1);

        // 0.3-bit glitch must not produce a byte or an error; next frame still received
        f0 = ferr_cnt;
        bus.rx = 1'b0;
        repeat (BIT * 3 / 10) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch rx_empty", bus.rx_empty, 1'b1);
        check("glitch frame_err", ferr_cnt - f0, 0);
        send_rx(8'h3C, 1'b1);
        repeat (BIT) @(negedge clk);
        check("after glitch rx_data", bus.rx_data, 8'h3C);
        pop_rx();

        // TX: 0x4E then eight random bytes queued during its start bit, ninth write dropped
        wc = cyc;
        bus.tx_data = 8'h4E;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        t = 0;
        while (bus.tx !== 1'b0 && t < 4 * BIT) begin
            @(negedge clk);
            t++;
        end
        check("tx first start latency", (cyc - wc >= 2) && (cyc - wc <= DIV + 2), 1'b1);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            bus.tx_data = b;
            bus.wr_en = 1'b1;
            if (tq.size() < 8) tq.push_back(b);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("tx_full with 8 queued", bus.tx_full, 1'b1);
        tx_frame(8'h4E, 9, prev);
        check("tx_full after pop", bus.tx_full, 1'b0);
        while (tq.size() > 0) begin
            b = tq.pop_front();
            tx_frame(b, 0, fall);
            check("tx back-to-back gap", (fall - prev >= 10 * BIT - 1) && (fall - prev <= 10 * BIT + 1), 1'b1);
            prev = fall;
        end
        lows = 0;
        repeat (3 * BIT) begin
            if (bus.tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("tx idle after queue (dropped write)", lows, 0);

        // Reset during the start bit of 0xFF with three more bytes queued
        foreach (vecs[i]) if (i < 4) begin
            bus.tx_data = (i == 0) ? 8'hFF : 8'(8'h11 * i);
            bus.wr_en = 1'b1;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        t = 0;
        while (bus.tx !== 1'b0 && t < 4 * BIT) begin
            @(negedge clk);
            t++;
        end
        repeat (BIT / 2) @(negedge clk);
        check("pre-reset tx low", bus.tx, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", bus.tx, 1'b1);
        check("async reset tx_full", bus.tx_full, 1'b0);
        check("async reset rx_empty", bus.rx_empty, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (25 * BIT) begin
            if (bus.tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("no frames after reset", lows, 0);

        // Transmitter still usable after reset
        bus.tx_data = 8'hA5;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        tx_frame(8'hA5, 0, fall);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
